// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one shift-add signed multiplier core among NREQ requesters.
// Optional WAIT-state watchdog: define MULT_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module mult_share_arbiter #(
    parameter int unsigned DW      = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*(DW+1)-1:0] req_mltnd,
    input  logic [NREQ*(DW+1)-1:0] req_mlter,
    output logic [NREQ-1:0]        req_ready,
    output logic                   mult_load,
    output logic                   mult_clean,
    output logic [DW:0]            mult_mltnd,
    output logic [DW:0]            mult_mlter,
    input  logic                   mult_ready,
    input  logic [2*DW-1:0]        mult_product,
    input  logic                   mult_sign,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*DW-1:0]        rsp_product,
    output logic                   rsp_sign,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_err
);

    localparam int unsigned OW = DW + 1;
    localparam int unsigned PW = 2 * DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    if (NREQ < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mult_share_arbiter: NREQ and TIMEOUT must be at least 1");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [OW-1:0]   r_mltnd;
    logic [OW-1:0]   r_mlter;
    logic [PW-1:0]   r_product;
    logic            r_sign;
    logic            r_err;
    logic            r_clean;
    logic            w_grant_any;
    logic [IDW-1:0]  w_grant_idx;
    logic [OW-1:0]   w_sel_mltnd;
    logic [OW-1:0]   w_sel_mlter;
    logic            w_accept;
    logic            w_handshake;
    logic            w_timeout;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // First valid requester at or after the round-robin pointer
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_grant_any && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_mltnd = '0;
        w_sel_mlter = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant_idx == IDW'(i)) begin
                w_sel_mltnd = req_mltnd[i*OW +: OW];
                w_sel_mlter = req_mlter[i*OW +: OW];
            end
        end
    end

    // The IDLE cycle carrying the clear pulse does not grant, so the core is clean before the next load
    assign w_accept    = (r_state == S_IDLE) && !r_clean && w_grant_any;
    assign w_handshake = (r_state == S_RESP) && rsp_ready;
    assign req_ready   = w_accept ? (NREQ'(1) << w_grant_idx) : '0;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_to_cnt <= r_to_cnt + CW'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !mult_ready && (r_to_cnt == CW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_WAIT;
            S_WAIT:  if (mult_ready || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_mltnd   <= '0;
            r_mlter   <= '0;
            r_product <= '0;
            r_sign    <= 1'b0;
            r_err     <= 1'b0;
            r_clean   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_clean <= w_handshake;
            if (w_accept) begin
                r_mltnd <= w_sel_mltnd;
                r_mlter <= w_sel_mlter;
                r_id    <= w_grant_idx;
            end
            if ((r_state == S_WAIT) && mult_ready) begin
                r_product <= mult_product;
                r_sign    <= mult_sign;
                r_err     <= 1'b0;
            end else if (w_timeout) begin
                r_product <= '0;
                r_sign    <= 1'b0;
                r_err     <= 1'b1;
            end
            if (w_handshake) begin
                r_rr_ptr <= wrap_idx(r_id, 1);
            end
        end
    end

    assign mult_load   = (r_state == S_LOAD);
    assign mult_clean  = r_clean;
    assign mult_mltnd  = r_mltnd;
    assign mult_mlter  = r_mlter;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_product = r_product;
    assign rsp_sign    = r_sign;
    assign rsp_id      = r_id;
    assign rsp_err     = r_err;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural shift-add core answering DW+2 cycles after load.
module tb_mult_share_arbiter;

    localparam int unsigned DW      = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned OW      = DW + 1;
    localparam int unsigned PW      = 2 * DW;
    localparam int unsigned L       = DW + 2;
    localparam int unsigned TIMEOUT = 32;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OW-1:0]   req_mltnd;
    logic [NREQ*OW-1:0]   req_mlter;
    logic [NREQ-1:0]      req_ready;
    logic                 mult_load;
    logic                 mult_clean;
    logic [OW-1:0]        mult_mltnd;
    logic [OW-1:0]        mult_mlter;
    logic                 mult_ready;
    logic [PW-1:0]        mult_product;
    logic                 mult_sign;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [PW-1:0]        rsp_product;
    logic                 rsp_sign;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mult_share_arbiter #(.DW(DW), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mltnd(req_mltnd), .req_mlter(req_mlter), .req_ready(req_ready),
        .mult_load(mult_load), .mult_clean(mult_clean), .mult_mltnd(mult_mltnd), .mult_mlter(mult_mlter),
        .mult_ready(mult_ready), .mult_product(mult_product), .mult_sign(mult_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .rsp_sign(rsp_sign), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: one-cycle ready pulse L cycles after the load cycle
    logic          core_busy  = 1'b0;
    logic          core_never = 1'b0;
    logic [7:0]    core_cnt   = '0;
    logic [OW-1:0] core_a     = '0;
    logic [OW-1:0] core_b     = '0;
    logic [OW-1:0] core_ma;
    logic [OW-1:0] core_mb;

    always @(posedge clk) begin
        if (mult_load) begin
            core_busy <= 1'b1;
            core_cnt  <= 8'(L - 1);
            core_a    <= mult_mltnd;
            core_b    <= mult_mlter;
        end else if (core_busy) begin
            if (core_cnt == 8'd0) core_busy <= 1'b0;
            else core_cnt <= core_cnt - 8'd1;
        end
    end

    always_comb begin
        core_ma      = core_a[OW-1] ? OW'(-core_a) : core_a;
        core_mb      = core_b[OW-1] ? OW'(-core_b) : core_b;
        mult_product = PW'(core_ma * core_mb);
        mult_sign    = core_a[OW-1] ^ core_b[OW-1];
        mult_ready   = core_busy && (core_cnt == 8'd0) && !core_never;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b);
        req_mltnd[i*OW +: OW] = a;
        req_mlter[i*OW +: OW] = b;
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = 0;
        while (req_ready === '0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last;
        logic [IDW-1:0] exp_id  [5];
        logic [PW-1:0]  exp_prd [4];
        logic           exp_sgn [4];

        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_prd = '{16'd12, 16'd42, 16'd18, 16'd256};
        exp_sgn = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; req_valid = '0; req_mltnd = '0; req_mlter = '0; rsp_ready = 1'b0;
        repeat (2) tick();

        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_mult_load", 32'(mult_load), 0);
        chk("rst_mult_clean", 32'(mult_clean), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_product", 32'(rsp_product), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        rst = 1'b0;
        tick();
        chk("idle_no_req_ready", 32'(req_ready), 0);

        // A: single request, 5 * -3
        set_ops(0, 9'd5, 9'h1FD);
        req_valid = 4'b0001;
        #1;
        chk("A_req_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("A_mult_load", 32'(mult_load), 1);
        chk("A_mult_mltnd", 32'(mult_mltnd), 32'h005);
        chk("A_mult_mlter", 32'(mult_mlter), 32'h1FD);
        chk("A_no_req_ready_load", 32'(req_ready), 0);
        tick();
        chk("A_load_single", 32'(mult_load), 0);
        wait_rsp(40, n);
        chk("A_latency", 32'(2 + n), 12);
        chk("A_rsp_valid", 32'(rsp_valid), 1);
        chk("A_product", 32'(rsp_product), 15);
        chk("A_sign", 32'(rsp_sign), 1);
        chk("A_id", 32'(rsp_id), 0);
        chk("A_err", 32'(rsp_err), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("A_clean_pulse", 32'(mult_clean), 1);
        chk("A_rsp_dropped", 32'(rsp_valid), 0);
        tick();
        chk("A_clean_single", 32'(mult_clean), 0);

        // B: reset while waiting on the core; pointer is 1, so 4'b0100 grants id 2
        set_ops(2, 9'd7, 9'd7);
        req_valid = 4'b0100;
        #1;
        chk("B_req_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("B_req_ready", 32'(req_ready), 0);
        chk("B_mult_load", 32'(mult_load), 0);
        chk("B_mult_clean", 32'(mult_clean), 0);
        chk("B_mult_mltnd", 32'(mult_mltnd), 0);
        chk("B_mult_mlter", 32'(mult_mlter), 0);
        chk("B_rsp_valid", 32'(rsp_valid), 0);
        chk("B_rsp_product", 32'(rsp_product), 0);
        chk("B_rsp_sign", 32'(rsp_sign), 0);
        chk("B_rsp_id", 32'(rsp_id), 0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rsp_valid === 1'b1 || mult_load === 1'b1) n++;
        end
        chk("B_no_activity_after_rst", 32'(n), 0);

        // C: all requesters held valid; expect 0,1,2,3,0 at one grant per L+4 cycles
        set_ops(0, 9'd3, 9'd4);
        set_ops(1, 9'h1F9, 9'd6);
        set_ops(2, 9'h1FE, 9'h1F7);
        set_ops(3, 9'h100, 9'd1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(40, n);
            chk("C_grant", 32'(req_ready), 32'(4'b0001 << exp_id[g]));
            if (g > 0) chk("C_spacing", 32'(cyc - last), L + 4);
            last = cyc;
            tick();
            chk("C_ready_single", 32'(req_ready), 0);
            wait_rsp(40, n);
            chk("C_rsp_valid", 32'(rsp_valid), 1);
            chk("C_id", 32'(rsp_id), 32'(exp_id[g]));
            chk("C_product", 32'(rsp_product), 32'(exp_prd[exp_id[g]]));
            chk("C_sign", 32'(rsp_sign), 32'(exp_sgn[exp_id[g]]));
            chk("C_err", 32'(rsp_err), 0);
        end

        // D: grant id 3, stall the response 10 cycles, then 4'b1001 wraps to id 0
        req_valid = 4'b1000;
        tick();
        chk("D_clean_cycle_clean", 32'(mult_clean), 1);
        chk("D_clean_cycle_no_grant", 32'(req_ready), 0);
        rsp_ready = 1'b0;
        tick();
        chk("D_grant3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b1001;
        wait_rsp(40, n);
        for (int k = 0; k < 10; k++) begin
            chk("D_hold_valid", 32'(rsp_valid), 1);
            chk("D_hold_product", 32'(rsp_product), 256);
            chk("D_hold_sign", 32'(rsp_sign), 1);
            chk("D_hold_id", 32'(rsp_id), 3);
            chk("D_hold_req_ready", 32'(req_ready), 0);
            chk("D_hold_load", 32'(mult_load), 0);
            chk("D_hold_clean", 32'(mult_clean), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("D_clean_pulse", 32'(mult_clean), 1);
        chk("D_clean_no_grant", 32'(req_ready), 0);
        tick();
        chk("D_wrap_grant0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_rsp(40, n);
        chk("D_wrap_id", 32'(rsp_id), 0);
        chk("D_wrap_product", 32'(rsp_product), 12);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();

`ifdef MULT_ARB_TIMEOUT_EN
        // E: core never answers; pointer is 1 so 4'b0010 grants id 1
        core_never = 1'b1;
        set_ops(1, 9'd9, 9'd9);
        req_valid = 4'b0010;
        #1;
        chk("E_req_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        wait_rsp(80, n);
        chk("E_timeout_cycles", 32'(n), TIMEOUT);
        chk("E_rsp_valid", 32'(rsp_valid), 1);
        chk("E_err", 32'(rsp_err), 1);
        chk("E_product", 32'(rsp_product), 0);
        chk("E_sign", 32'(rsp_sign), 0);
        chk("E_id", 32'(rsp_id), 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("E_clean_pulse", 32'(mult_clean), 1);
        core_never = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
